mac_sched: RTL and testbench
============================

MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 The block SHALL have the port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, width 1: asynchronous active-low reset.
REQ-003 The block SHALL have the port start, input, width 1: begin one matrix-vector job; sampled only in IDLE.
REQ-004 The block SHALL have the port request, output, width 1: fetch request to the fetch unit.
REQ-005 The block SHALL have the port fetch_done, input, width 1: fetch unit reports that A and B are valid.
REQ-006 The block SHALL have the port A, input, 64 x 8: unpacked matrix, row-major, element (r,k) at A[r*8+k].
REQ-007 The block SHALL have the port B, input, 8 x 8: unpacked vector B[0:7].
REQ-008 The block SHALL have the port a_col, output, 8 x 8: a_col[r] is the A operand for MAC row r.
REQ-009 The block SHALL have the port b_elem, output, 8 x 8: b_elem[r] is the B operand for MAC row r.
REQ-010 The block SHALL have the port mac_en, output, width 8: per-row accumulate enable.
REQ-011 The block SHALL have the port mac_clr, output, width 1: clears all MAC accumulators.
REQ-012 The block SHALL have the ports busy and done, each output, width 1: busy means not IDLE; done is a one-cycle completion pulse.

Function
REQ-013 The block SHALL register every output, with all outputs driven from state or registers only.
REQ-014 The block SHALL implement the states IDLE, FETCH, CLR, RUN, DRAIN and DONE.
REQ-015 IDLE SHALL move to FETCH on the edge where start=1; start in any other state SHALL be ignored.
REQ-016 In FETCH, request SHALL be held at 1 until fetch_done=1 is sampled.
REQ-017 On the edge where fetch_done=1 is sampled, the block SHALL snapshot A and B into internal registers, clear request and enter CLR.
REQ-018 fetch_done=1 in any state other than FETCH SHALL be ignored.
REQ-019 CLR SHALL last exactly one cycle with mac_clr=1 and mac_en=0; mac_clr SHALL be 0 in every other state.
REQ-020 RUN SHALL use a cycle counter t starting at 0.
REQ-021 Row r SHALL be active when k=t-d(r) lies in 0..7, where d(r) is the row skew.
REQ-022 For an active row, the block SHALL drive mac_en[r]=1, a_col[r]=Asnap[r*8+k] and b_elem[r]=Bsnap[k].
REQ-023 For an inactive row, the block SHALL drive mac_en[r]=0 and a_col[r]=b_elem[r]=0.
REQ-024 RUN SHALL last 8+max(d) cycles, then move to DRAIN.
REQ-025 DRAIN SHALL last one cycle with mac_en=0, covering MAC pipeline latency, then move to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 start=1 in the DONE cycle SHALL be ignored; a new job needs start in IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 The counter t SHALL be 4 bits and SHALL be cleared on entry to RUN.
REQ-030 The counter t SHALL NOT wrap within a job.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously, force IDLE and set request, mac_clr, mac_en, busy, done, a_col, b_elem and t to 0.
REQ-032 Reset asserted mid-job in any state SHALL abandon the job with no done pulse.
REQ-033 The snapshot registers SHALL reset to 0.
REQ-034 The first start after rst_n deassertion SHALL be honoured normally.

Configuration
REQ-035 The block SHALL support one compile-time feature, macro MAC_SCHED_SKEW_EN.
REQ-036 When MAC_SCHED_SKEW_EN is defined, d(r)=r (systolic skew): RUN SHALL last 15 cycles, and row r SHALL be active at t=r..r+7.
REQ-037 When MAC_SCHED_SKEW_EN is undefined, d(r)=0: RUN SHALL last 8 cycles with mac_en=8'hFF throughout.
REQ-038 All other behaviour SHALL be identical with and without MAC_SCHED_SKEW_EN.

Verification
REQ-039 Basic job, no skew: with A[r*8+k]=r*8+k+1 and B[k]=0x81+k, pulse start, then fetch_done 3 cycles later. The bench SHALL check:
- request high from the cycle after start until fetch_done;
- a one-cycle mac_clr;
- 8 RUN cycles with mac_en=0xFF;
- at t=0, a_col[0]=0x01 and b_elem[0]=0x81;
- at t=7, b_elem[7]=0x88 and a_col[7]=0x40;
- done exactly 10 cycles after the fetch_done edge.
REQ-040 Skew, MAC_SCHED_SKEW_EN defined, same data: the bench SHALL check:
- t=0: mac_en=0x01;
- t=7: mac_en=0xFF;
- t=14: mac_en=0x80, a_col[7]=0x40;
- done 17 cycles after the fetch_done edge.
REQ-041 Ignored inputs: start pulses in FETCH and RUN, and fetch_done pulses in IDLE and RUN, SHALL produce no second job, no early done, and request only once.
REQ-042 Snapshot: changing A and B during RUN SHALL leave a_col and b_elem equal to the values captured at fetch_done.
REQ-043 Reset mid-RUN at t=4: all outputs SHALL go 0 immediately and no done SHALL occur; a following start SHALL complete a full job.
REQ-044 Back-to-back: start asserted continuously SHALL begin the next job in the first IDLE cycle after done.

Source files
------------

// File: rtl/mac_sched.sv
// mac_sched: sequences one 8x8 matrix-vector job onto an 8-row MAC array.
// Define MAC_SCHED_SKEW_EN for systolic skew (row r starts r cycles late).
module mac_sched (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       request,
   input  logic       fetch_done,
   input  logic [7:0] A      [0:63],
   input  logic [7:0] B      [0:7],
   output logic [7:0] a_col  [0:7],
   output logic [7:0] b_elem [0:7],
   output logic [7:0] mac_en,
   output logic       mac_clr,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CLR,
      RUN,
      DRAIN,
      DONE
   } state_t;

`ifdef MAC_SCHED_SKEW_EN
   localparam logic [3:0] RUN_LAST = 4'd14;
`else
   localparam logic [3:0] RUN_LAST = 4'd7;
`endif

   state_t     state;
   state_t     state_nxt;
   logic [3:0] t;
   logic [3:0] t_nxt;
   logic       snap_load;
   logic       request_nxt;
   logic       mac_clr_nxt;
   logic       busy_nxt;
   logic       done_nxt;
   logic [7:0] en_nxt;
   logic [7:0] a_nxt  [0:7];
   logic [7:0] b_nxt  [0:7];
   logic [4:0] k_row  [0:7];
   logic [7:0] a_snap [0:63];
   logic [7:0] b_snap [0:7];

   // Every output is registered from the value it must show in the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         t       <= '0;
         request <= 1'b0;
         mac_clr <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mac_en  <= '0;
         for (int r = 0; r < 8; r++) begin
            a_col[r]  <= '0;
            b_elem[r] <= '0;
         end
      end else begin
         state   <= state_nxt;
         t       <= t_nxt;
         request <= request_nxt;
         mac_clr <= mac_clr_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         mac_en  <= en_nxt;
         for (int r = 0; r < 8; r++) begin
            a_col[r]  <= a_nxt[r];
            b_elem[r] <= b_nxt[r];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) a_snap[i] <= '0;
         for (int k = 0; k < 8; k++)  b_snap[k] <= '0;
      end else if (snap_load) begin
         for (int i = 0; i < 64; i++) a_snap[i] <= A[i];
         for (int k = 0; k < 8; k++)  b_snap[k] <= B[k];
      end
   end

   always_comb begin
      state_nxt = state;
      t_nxt     = '0;
      snap_load = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: begin
            if (fetch_done) begin
               state_nxt = CLR;
               snap_load = 1'b1;
            end
         end
         CLR:   state_nxt = RUN;
         RUN: begin
            if (t == RUN_LAST) state_nxt = DRAIN;
            else               t_nxt     = t + 4'd1;
         end
         DRAIN: state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      request_nxt = (state_nxt == FETCH);
      mac_clr_nxt = (state_nxt == CLR);
      done_nxt    = (state_nxt == DONE);
      busy_nxt    = (state_nxt != IDLE);
   end

   // k_row is the element index row r consumes; out-of-range (or wrapped) means idle.
   always_comb begin
      en_nxt = '0;
      for (int r = 0; r < 8; r++) begin
         a_nxt[r] = '0;
         b_nxt[r] = '0;
`ifdef MAC_SCHED_SKEW_EN
         k_row[r] = {1'b0, t_nxt} - 5'(r);
`else
         k_row[r] = {1'b0, t_nxt};
`endif
         if (state_nxt == RUN && k_row[r] < 5'd8) begin
            en_nxt[r] = 1'b1;
            a_nxt[r]  = a_snap[{3'(r), k_row[r][2:0]}];
            b_nxt[r]  = b_snap[k_row[r][2:0]];
         end
      end
   end

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: randomized jobs checked by a scoreboard fed from a job-level model.
// Works with or without MAC_SCHED_SKEW_EN.
module tb_mac_sched;

`ifdef MAC_SCHED_SKEW_EN
   localparam int RUN_LEN = 15;
`else
   localparam int RUN_LEN = 8;
`endif
   localparam int MAXC = 4000;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       request;
   logic       fetch_done;
   logic [7:0] A      [0:63];
   logic [7:0] B      [0:7];
   logic [7:0] a_col  [0:7];
   logic [7:0] b_elem [0:7];
   logic [7:0] mac_en;
   logic       mac_clr;
   logic       busy;
   logic       done;

   typedef struct packed {
      logic [31:0] at;
      logic [7:0]  en;
      logic [63:0] a;
      logic [63:0] b;
   } beat_t;

   beat_t       beat_q [$];
   int          done_q [$];
   logic        exp_req  [MAXC];
   logic        exp_clr  [MAXC];
   logic        exp_busy [MAXC];
   int          cyc;
   int          n_checks;
   int          n_fail;
   logic [63:0] a_pk;
   logic [63:0] b_pk;

   mac_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .request    (request),
      .fetch_done (fetch_done),
      .A          (A),
      .B          (B),
      .a_col      (a_col),
      .b_elem     (b_elem),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      a_pk = '0;
      b_pk = '0;
      for (int r = 0; r < 8; r++) begin
         a_pk[r*8 +: 8] = a_col[r];
         b_pk[r*8 +: 8] = b_elem[r];
      end
   end

   function automatic int skew_of(input int r);
`ifdef MAC_SCHED_SKEW_EN
      return r;
`else
      return 0 * r;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < 64; i++) A[i] = 8'($urandom);
      for (int k = 0; k < 8; k++)  B[k] = 8'($urandom);
   endtask

   // Model: the job snapshot is taken where fetch_done is driven; each RUN
   // cycle t feeds row r element k = t - d(r) when that lies in 0..7.
   task automatic push_job(input int cf);
      for (int t = 0; t < RUN_LEN; t++) begin
         beat_t bt;
         bt    = '0;
         bt.at = 32'(cf + 2 + t);
         for (int r = 0; r < 8; r++) begin
            int k;
            k = t - skew_of(r);
            if (k >= 0 && k < 8) begin
               bt.en[r]       = 1'b1;
               bt.a[r*8 +: 8] = A[r*8 + k];
               bt.b[r*8 +: 8] = B[k];
            end
         end
         beat_q.push_back(bt);
      end
      done_q.push_back(cf + RUN_LEN + 3);
   endtask

   // Monitor: per-cycle control timeline plus scoreboard pops on mac_en / done.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         check("request", 64'(request), 64'(exp_req[cyc]));
         check("mac_clr", 64'(mac_clr), 64'(exp_clr[cyc]));
         check("busy",    64'(busy),    64'(exp_busy[cyc]));
      end
      if (mac_en != 8'h00) begin
         if (beat_q.size() == 0) begin
            check("unexpected_mac_en", 64'(mac_en), 64'h0);
         end else begin
            beat_t bt;
            bt = beat_q.pop_front();
            check("beat_cycle", 64'(cyc), 64'(bt.at));
            check("mac_en",     64'(mac_en), 64'(bt.en));
            check("a_col",      a_pk, bt.a);
            check("b_elem",     b_pk, bt.b);
         end
      end else begin
         check("idle_a_col",  a_pk, 64'h0);
         check("idle_b_elem", b_pk, 64'h0);
      end
      if (done) begin
         if (done_q.size() == 0) check("unexpected_done", 64'(done), 64'h0);
         else                    check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_request"}, 64'(request), 64'h0);
      check({tag, "_busy"},    64'(busy),    64'h0);
      check({tag, "_done"},    64'(done),    64'h0);
      check({tag, "_mac_clr"}, 64'(mac_clr), 64'h0);
      check({tag, "_mac_en"},  64'(mac_en),  64'h0);
      check({tag, "_a_col"},   a_pk,         64'h0);
      check({tag, "_b_elem"},  b_pk,         64'h0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge following
   // the IDLE-entry edge (or right after a mid-RUN reset is released).
   task automatic applyStimulus(input int g, input bit spur, input bit hold,
                                input bit rst_mid, input bit directed);
      int cs, cf, cd;
      cs         = cyc;
      cf         = cs + g;
      cd         = cf + RUN_LEN + 3;
      start      = 1'b1;
      fetch_done = 1'b0;
      for (int c = cs + 1; c <= cf; c++) exp_req[c] = 1'b1;
      for (int c = cs + 1; c <= cd; c++) exp_busy[c] = 1'b1;
      exp_clr[cf + 1] = 1'b1;
      for (int n = cs + 1; n <= cf; n++) begin
         @(negedge clk);
         start = hold || (spur && $urandom_range(0, 1) == 1);
         if (!directed) scramble();
         if (n == cf) begin
            fetch_done = 1'b1;
            push_job(cf);
         end
      end
      for (int n = cf + 1; n <= cd; n++) begin
         @(negedge clk);
         fetch_done = spur && n >= cf + 2 && n <= cf + RUN_LEN && $urandom_range(0, 1) == 1;
         start = hold || (spur && ((n >= cf + 2 && n <= cf + RUN_LEN) || n == cd)
                          && $urandom_range(0, 1) == 1);
         scramble();
         if (directed && n == cf + 2) begin
            check("t0_a_col0",  64'(a_col[0]),  64'h01);
            check("t0_b_elem0", 64'(b_elem[0]), 64'h81);
`ifdef MAC_SCHED_SKEW_EN
            check("t0_mac_en",  64'(mac_en),    64'h01);
`else
            check("t0_mac_en",  64'(mac_en),    64'hFF);
`endif
         end
         if (directed && n == cf + 9) begin
            check("t7_mac_en", 64'(mac_en), 64'hFF);
`ifndef MAC_SCHED_SKEW_EN
            check("t7_b_elem7", 64'(b_elem[7]), 64'h88);
            check("t7_a_col7",  64'(a_col[7]),  64'h40);
`endif
         end
`ifdef MAC_SCHED_SKEW_EN
         if (directed && n == cf + 16) begin
            check("t14_mac_en",  64'(mac_en),   64'h80);
            check("t14_a_col7",  64'(a_col[7]), 64'h40);
         end
`endif
         if (rst_mid && n == cf + 6) begin
            #2;
            rst_n      = 1'b0;
            start      = 1'b0;
            fetch_done = 1'b0;
            #1;
            check_all_zero("midrst");
            for (int c = n + 1; c < MAXC; c++) begin
               exp_req[c]  = 1'b0;
               exp_clr[c]  = 1'b0;
               exp_busy[c] = 1'b0;
            end
            beat_q.delete();
            done_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end
      @(negedge clk);
      fetch_done = 1'b0;
      start      = hold;
   endtask

   task automatic checkOutput();
      check("leftover_beats", 64'(beat_q.size()), 64'h0);
      check("leftover_done",  64'(done_q.size()), 64'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cyc        = 0;
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b1;
      start      = 1'b0;
      fetch_done = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
         exp_req[c]  = 1'b0;
         exp_clr[c]  = 1'b0;
         exp_busy[c] = 1'b0;
      end
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) A[r*8 + k] = 8'(r*8 + k + 1);
         B[r] = 8'(8'h81 + r);
      end
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed job");
      applyStimulus(3, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] random jobs with ignored start/fetch_done pulses");
      for (int j = 0; j < 6; j++) begin
         int idle;
         applyStimulus($urandom_range(1, 4), 1'b1, 1'b0, 1'b0, 1'b0);
         idle = $urandom_range(0, 3);
         for (int i = 0; i < idle; i++) begin
            fetch_done = ($urandom_range(0, 1) == 1);
            @(negedge clk);
         end
         fetch_done = 1'b0;
      end

      $display("[TB] back-to-back jobs");
      applyStimulus(3, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset mid-RUN then full job");
      applyStimulus(3, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(2, 1'b1, 1'b0, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
